seg_scan_driver: RTL and testbench

Parametrised multi-digit 7-segment display driver for the board's common-anode displays. It converts a binary value to BCD using a sequential double-dabble, then time-multiplexes the digits onto one shared active-low segment bus with per-digit anode enables. It supersedes the fixed two-digit combinational lookup. It sits between any counter or measurement block and the board's display pins.

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_bin2bcd.sv | 85 ++++++++
 rtl/seg_scan_driver.sv | 85 ++++++++
 tb/tb_seg_scan_driver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the multi-digit 7-segment scan driver.
// Segment order is {a,b,c,d,e,f,g,dp}, MSB = a, active-low (0 = lit).
package seg_pkg;

    localparam int unsigned SEG_W = 8;

    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
        8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
    };
    localparam logic [SEG_W-1:0] SEG_DASH  = 8'hFD;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    // BCD nibble to segment pattern; non-decimal nibbles show blank.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] nib);
        logic [SEG_W-1:0] s;
        s = SEG_BLANK;
        if (nib <= 4'd9) s = SEG_DIGIT[nib];
        return s;
    endfunction

    // 10**n, used for the capture-time overflow threshold.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter (IDLE -> SHIFT x BIN_W -> DONE).
// bcd_out and overflow update together on the DONE edge; load is ignored while busy.
module seg_bin2bcd
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BIN_W-1:0]        bin_in,
    input  logic                    load,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    overflow
);

    localparam int unsigned       BCD_W     = 4 * NUM_DIGITS;
    localparam int unsigned       CNT_W     = $clog2(BIN_W + 1);
    localparam logic [63:0]       OVF_LIMIT = pow10(NUM_DIGITS);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(BIN_W - 1);

    conv_state_t       state, state_nxt;
    logic [BIN_W-1:0]  cap_q;
    logic [BCD_W-1:0]  work_q;
    logic [BCD_W-1:0]  work_adj;
    logic [BCD_W-1:0]  work_step;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_cap_q;
    logic              accept;

    assign accept = (state == CONV_IDLE) && load;
    assign busy   = (state != CONV_IDLE);

    // Conversion state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CONV_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: SHIFT runs exactly BIN_W iterations, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE:  if (load) state_nxt = CONV_SHIFT;
            CONV_SHIFT: if (cnt_q == LAST_ITER) state_nxt = CONV_DONE;
            CONV_DONE:  state_nxt = CONV_IDLE;
            default:    state_nxt = CONV_IDLE;
        endcase
    end

    // One double-dabble iteration: add 3 to nibbles >= 5, shift in next MSB; top carry dropped.
    always_comb begin
        work_adj = work_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
        work_step = {work_adj[BCD_W-2:0], cap_q[BIN_W-1]};
    end

    // Capture, iterate and publish datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q     <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_cap_q <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            cap_q     <= bin_in;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_cap_q <= (64'(bin_in) >= OVF_LIMIT);
        end else if (state == CONV_SHIFT) begin
            work_q <= work_step;
            cap_q  <= cap_q << 1;
            cnt_q  <= cnt_q + CNT_W'(1);
        end else if (state == CONV_DONE) begin
            bcd_out  <= work_q;
            overflow <= ovf_cap_q;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multi-digit common-anode 7-segment scan driver: converts bin_in to BCD and
// time-multiplexes digits onto an active-low segment bus with active-low anodes.
// Optional build macro SEG_LZ_BLANK_EN: blank leading zeros (digit 0 always shown).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int unsigned      PRE_W    = $clog2(SCAN_DIV);
    localparam int unsigned      IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] digits;
    logic [PRE_W-1:0]        pre_q;
    logic [IDX_W-1:0]        idx_q;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic [SEG_W-1:0]        seg_nxt;

    seg_bin2bcd #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .bin_in   (bin_in),
        .load     (load),
        .busy     (busy),
        .bcd_out  (digits),
        .overflow (overflow)
    );

    // Slot prescaler and scan index; index advances on prescaler terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Pattern for the currently scanned digit: dash on overflow, else digit or blank.
    always_comb begin
        cur_nib   = digits[{idx_q, 2'b00} +: 4];
        cur_blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        cur_blank = (idx_q != '0);
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i >= 32'(idx_q) && digits[4*i +: 4] != 4'd0) cur_blank = 1'b0;
        end
`endif
        if (overflow)       seg_nxt = SEG_DASH;
        else if (cur_blank) seg_nxt = SEG_BLANK;
        else                seg_nxt = seg_encode(cur_nib);
    end

    // seg and an registered from the same index so digit and anode never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_nxt;
            an  <= ~(NUM_DIGITS'(1) << idx_q);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (NUM_DIGITS=4, BIN_W=14, SCAN_DIV=4).
// A cycle-level reference model derives outputs from the displayed value with
// decimal arithmetic; directed checks pin the model with literal patterns.
`timescale 1ns/1ps
module tb_seg_scan_driver;

    localparam int unsigned ND  = 4;
    localparam int unsigned BW  = 14;
    localparam int unsigned SD  = 4;
    localparam int unsigned LIM = 10000;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [BW-1:0] bin_in;
    logic          busy;
    logic          overflow;
    logic [7:0]    seg;
    logic [ND-1:0] an;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0] segtab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    seg_scan_driver #(
        .NUM_DIGITS (ND),
        .BIN_W      (BW),
        .SCAN_DIV   (SD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bin_in   (bin_in),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            if (bad <= 40) $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, expv);
        end
    endtask

    // Pattern a digit position must show for a given displayed value.
    function automatic logic [7:0] seg_of(input int unsigned v, input bit o, input int unsigned i);
        int unsigned p;
        p = 1;
        for (int unsigned j = 0; j < i; j++) p = p * 10;
        if (o) return 8'hFD;
`ifdef SEG_LZ_BLANK_EN
        if (i != 0 && v < p) return 8'hFF;
`endif
        return segtab[(v / p) % 10];
    endfunction

    // Reference model state: edges since reset, conversion in flight, displayed value.
    int unsigned m_e = 0, m_k = 0, m_cval = 0, m_dval = 0;
    bit          m_act = 0, m_dovf = 0, m_busy = 0;
    logic [7:0]    m_seg = 8'hFF;
    logic [ND-1:0] m_an  = '1;

    // Model step and comparison once per cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_e = 0; m_act = 0; m_dval = 0; m_dovf = 0; m_busy = 0;
                m_seg = 8'hFF; m_an = '1;
            end else begin
                int unsigned idx;
                m_e++;
                idx   = ((m_e - 1) / SD) % ND;
                m_seg = seg_of(m_dval, m_dovf, idx);
                m_an  = ND'(~(32'd1 << idx));
                if (m_act) begin
                    if (m_e == m_k + BW + 1) begin
                        m_dval = m_cval;
                        m_dovf = (m_cval >= LIM);
                        m_act  = 0;
                    end
                end else if (load) begin
                    m_cval = 32'(bin_in);
                    m_k    = m_e;
                    m_act  = 1;
                end
                m_busy = m_act;
            end
            check("model_seg",  32'(seg),      32'(m_seg));
            check("model_an",   32'(an),       32'(m_an));
            check("model_busy", 32'(busy),     32'(m_busy));
            check("model_ovf",  32'(overflow), 32'(m_dovf));
        end
    end

    task automatic do_load(input int unsigned v, output int unsigned nb);
        @(negedge clk); #2;
        bin_in = BW'(v);
        load   = 1'b1;
        @(negedge clk); #2;
        load   = 1'b0;
        nb = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic show(input string nm, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] want [ND];
        logic [7:0] got  [ND];
        want = '{d0, d1, d2, d3};
        for (int j = 0; j < ND; j++) got[j] = 8'hEE;
        @(negedge clk);
        for (int c = 0; c < ND * SD; c++) begin
            @(negedge clk);
            for (int j = 0; j < ND; j++) if (an[j] == 1'b0) got[j] = seg;
        end
        for (int j = 0; j < ND; j++)
            check($sformatf("%s_d%0d", nm, j), 32'(got[j]), 32'(want[j]));
    endtask

    function automatic int unsigned pick();
        int unsigned r;
        r = $urandom_range(0, 3);
        if (r == 0) return $urandom_range(0, 99);
        if (r == 1) return $urandom_range(9990, 10010);
        return $urandom_range(0, 16383);
    endfunction

    initial begin
        #2_000_000;
        total++; bad++;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nb;
        rst = 1'b1; load = 1'b0; bin_in = '0;
        repeat (3) @(negedge clk);
        check("rst_seg",  32'(seg),  32'h0000_00FF);
        check("rst_an",   32'(an),   32'h0000_000F);
        check("rst_busy", 32'(busy), 32'h0);
        #2 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("slot0_an",  32'(an),  (i < 4) ? 32'hE : 32'hD);
            check("slot0_seg", 32'(seg), 32'h03);
        end

        do_load(1234, nb);
        check("busy_len_1234", nb, 15);
        check("ovf_1234", 32'(overflow), 32'h0);
        show("v1234", 8'h99, 8'h0D, 8'h25, 8'h9F);

        @(negedge clk); #2 bin_in = BW'(9999); load = 1'b1;
        @(negedge clk); #2 bin_in = BW'(5678);
        repeat (2) begin @(negedge clk); #2; end
        @(negedge clk); #2 load = 1'b0;
        nb = 0;
        for (int i = 0; i < 40 && busy; i++) begin nb++; @(negedge clk); end
        check("busy_end_9999", 32'(busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_second_conv", 32'(busy), 32'h0);
        end
        show("v9999", 8'h09, 8'h09, 8'h09, 8'h09);

        do_load(12000, nb);
        check("busy_len_12000", nb, 15);
        check("ovf_12000", 32'(overflow), 32'h1);
        show("v12000", 8'hFD, 8'hFD, 8'hFD, 8'hFD);

        do_load(42, nb);
        check("ovf_42", 32'(overflow), 32'h0);
`ifdef SEG_LZ_BLANK_EN
        show("v42", 8'h25, 8'h99, 8'hFF, 8'hFF);
        do_load(7, nb);    show("v7",    8'h1F, 8'hFF, 8'hFF, 8'hFF);
        do_load(0, nb);    show("v0",    8'h03, 8'hFF, 8'hFF, 8'hFF);
        do_load(1005, nb); show("v1005", 8'h49, 8'h03, 8'h03, 8'h9F);
`else
        show("v42", 8'h25, 8'h99, 8'h03, 8'h03);
        do_load(7, nb);    show("v7",    8'h1F, 8'h03, 8'h03, 8'h03);
        do_load(1005, nb); show("v1005", 8'h49, 8'h03, 8'h03, 8'h9F);
`endif

        @(negedge clk); #2 bin_in = BW'(1234); load = 1'b1;
        @(negedge clk); #2 load = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy),     32'h0);
        check("midrst_seg",  32'(seg),      32'hFF);
        check("midrst_an",   32'(an),       32'hF);
        check("midrst_ovf",  32'(overflow), 32'h0);
        @(negedge clk); #2 rst = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        show("after_rst", 8'h03, 8'hFF, 8'hFF, 8'hFF);
`else
        show("after_rst", 8'h03, 8'h03, 8'h03, 8'h03);
`endif
        do_load(88, nb);
        check("busy_len_88", nb, 15);
`ifdef SEG_LZ_BLANK_EN
        show("v88", 8'h01, 8'h01, 8'hFF, 8'hFF);
`else
        show("v88", 8'h01, 8'h01, 8'h03, 8'h03);
`endif

        for (int n = 0; n < 150; n++) begin
            int unsigned w;
            w = $urandom_range(1, 3);
            for (int j = 0; j < int'(w); j++) begin
                @(negedge clk); #2;
                load   = 1'b1;
                bin_in = BW'(pick());
            end
            @(negedge clk); #2 load = 1'b0;
            if ($urandom_range(0, 29) == 0) begin
                repeat ($urandom_range(0, 14)) @(negedge clk);
                #2 rst = 1'b1;
                @(negedge clk); #2 rst = 1'b0;
            end
            repeat ($urandom_range(0, 25)) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
